multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS32 core.
- Sequences one instruction over 3–5 cycles and drives the datapath mux selects and register and memory enables.
- Generates the 2-bit alu_op consumed by the ALU control decoder.
- Supports memory wait states via mem_ready; counts retired instructions; traps on unsupported opcodes.

Parameters:
- MEM_WAIT_EN, 1, 1 = honour mem_ready in memory states; 0 = treat mem_ready as constantly 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory has completed the current access this cycle.
- pc_en  out  1  PC register write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = funct-decoded.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- illegal_op  out  1  sticky flag: unsupported opcode trapped.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State register and instr_count reset asynchronously on rst_n = 0 (state to FETCH, counter to 0); release is synchronous to clk.
- All other outputs are Moore decodes of the state register. Exception: pc_en and ir_write also depend on mem_ready/zero, as stated below.
- States and actions (any output not listed is 0; alu_op = 00 unless listed):
  - FETCH: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01; ir_write = pc_en = mem_ready. Goes to DECODE when mem_ready, else stays.
  - DECODE: alu_src_a = 0, alu_src_b = 11 (precomputes the branch target). Dispatch on opcode:
    - 100011 (LW) or 101011 (SW) -> MEMADR
    - 000000 (R-type) -> EXECUTE
    - 000100 (BEQ) -> BRANCH
    - 001000 (ADDI) -> ADDIEXEC
    - 000010 (J) -> JUMP
    - any other -> ILLEGAL
  - MEMADR: alu_src_a = 1, alu_src_b = 10. Goes to MEMRD for LW, MEMWR for SW.
  - MEMRD: mem_read = 1, iord = 1. Goes to MEMWB when mem_ready, else stays.
  - MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Retires, -> FETCH.
  - MEMWR: mem_write = 1, iord = 1. When mem_ready: retires, -> FETCH; else stays.
  - EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 10. -> ALUWB.
  - ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Retires, -> FETCH.
  - BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_src = 01, pc_en = zero. Retires, -> FETCH.
  - ADDIEXEC: alu_src_a = 1, alu_src_b = 10. -> ADDIWB.
  - ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Retires, -> FETCH.
  - JUMP: pc_src = 10, pc_en = 1. Retires, -> FETCH.
  - ILLEGAL: illegal_op = 1, all enables 0. Stays until reset; no retire.
- Retire rules:
  - "Retires" means instr_done = 1 for that single cycle.
  - instr_count increments by 1 on the clock edge leaving a retiring state, wrapping modulo 2^CNT_W.
  - MEMWR retires only in the cycle where mem_ready = 1.
- Wait states: while stalled in FETCH, MEMRD or MEMWR, request outputs are held constant and pc_en/ir_write stay 0.
- With MEM_WAIT_EN = 0, each memory state lasts exactly 1 cycle.
- Fixed CPI (memory 0-wait):
  - LW = 5
  - SW = 4
  - R-type = 4
  - ADDI = 4
  - BEQ = 3
  - J = 3
- opcode is sampled only in DECODE and MEMADR; changes in other states are ignored.
- Reset asserted mid-instruction: state returns to FETCH immediately and asynchronously, and all enables drop in the same cycle. The partial instruction is discarded and not counted.
- mem_ready outside memory states is ignored.
- The unreachable state encoding decodes to all-zero outputs and next state FETCH.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - alu_op encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - alu_src_b and pc_src encodings
  - state enum typedef ctrl_state_t
- Single module; the FSM next-state and output decode stay inline.
- The retire counter is simple enough not to warrant a sub-module.

Test Plan:
- Reset then R-type (opcode 000000), mem_ready = 1: states FETCH, DECODE, EXECUTE, ALUWB. alu_op = 10 in EXECUTE; reg_write = 1, reg_dst = 1 in ALUWB; instr_done pulses at cycle 4; instr_count = 1.
- LW with mem_ready low for 2 cycles in MEMRD: 7 cycles total. mem_read and iord held at 1 during the stall; reg_write and mem_to_reg = 1 in MEMWB.
- BEQ with zero = 1, then zero = 0: pc_en = 1 in BRANCH with pc_src = 01 and alu_op = 01 for the first; pc_en = 0 for the second; both retire in 3 cycles.
- J then SW: J gives pc_en = 1 with pc_src = 10 at cycle 3. SW asserts mem_write = 1 in its 4th cycle. instr_count advances by 2.
- Opcode 111111: ILLEGAL entered after DECODE; illegal_op stays 1 for 20 cycles with no enables asserted and instr_count unchanged; rst_n low clears it.
- rst_n pulsed low during MEMADR: all outputs 0 in the same cycle, restart in FETCH, count not incremented.
- CNT_W = 4 with 16 ADDIs: instr_count wraps 15 -> 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS32 core: opcodes, ALU/mux selects
// and the control FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_ILLEGAL  = 4'd12
    } ctrl_state_t;

    // Opcode dispatch taken from DECODE; anything unsupported traps.
    function automatic ctrl_state_t dispatch(input logic [5:0] op);
        ctrl_state_t ns;
        case (op)
            OP_LW, OP_SW: ns = S_MEMADR;
            OP_RTYPE:     ns = S_EXECUTE;
            OP_BEQ:       ns = S_BRANCH;
            OP_ADDI:      ns = S_ADDIEXEC;
            OP_J:         ns = S_JUMP;
            default:      ns = S_ILLEGAL;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS32 core: sequences each instruction,
// drives datapath selects/enables and counts retired instructions.
module multicycle_control
    import mips_pkg::*;
#(
    parameter logic MEM_WAIT_EN = 1'b1,
    parameter int   CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    ctrl_state_t      r_state;
    ctrl_state_t      w_next_state;
    logic             w_ready;
    logic [CNT_W-1:0] r_count;

    assign w_ready     = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign instr_count = r_count;

    // State register; reset abandons any partial instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter, advances on the edge leaving a retiring state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else if (instr_done) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    // Moore output decode and next state; all outputs are forced low while in reset.
    always_comb begin
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_op       = ALUOP_ADD;
        pc_src       = PCSRC_ALU;
        instr_done   = 1'b0;
        illegal_op   = 1'b0;
        w_next_state = r_state;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read     = 1'b1;
                    alu_src_b    = SRCB_FOUR;
                    ir_write     = w_ready;
                    pc_en        = w_ready;
                    w_next_state = w_ready ? S_DECODE : S_FETCH;
                end
                S_DECODE: begin
                    alu_src_b    = SRCB_IMM_SH2;
                    w_next_state = dispatch(opcode);
                end
                S_MEMADR: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                end
                S_MEMRD: begin
                    mem_read     = 1'b1;
                    iord         = 1'b1;
                    w_next_state = w_ready ? S_MEMWB : S_MEMRD;
                end
                S_MEMWB: begin
                    reg_write    = 1'b1;
                    mem_to_reg   = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_MEMWR: begin
                    mem_write    = 1'b1;
                    iord         = 1'b1;
                    instr_done   = w_ready;
                    w_next_state = w_ready ? S_FETCH : S_MEMWR;
                end
                S_EXECUTE: begin
                    alu_src_a    = 1'b1;
                    alu_op       = ALUOP_FUNCT;
                    w_next_state = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write    = 1'b1;
                    reg_dst      = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a    = 1'b1;
                    alu_op       = ALUOP_SUB;
                    pc_src       = PCSRC_ALUOUT;
                    pc_en        = zero;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_ADDIEXEC: begin
                    alu_src_a    = 1'b1;
                    alu_src_b    = SRCB_IMM;
                    w_next_state = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_write    = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_JUMP: begin
                    pc_src       = PCSRC_JUMP;
                    pc_en        = 1'b1;
                    instr_done   = 1'b1;
                    w_next_state = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal_op   = 1'b1;
                    w_next_state = S_ILLEGAL;
                end
                default: begin
                    w_next_state = S_FETCH;
                end
            endcase
        end else begin
            w_next_state = S_FETCH;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model checked
// every cycle, plus directed instruction sequences with hand-computed probes.
module tb_multicycle_control;
    import mips_pkg::*;

    localparam int C_R = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_ADDI = 4, C_J = 5, C_ILL = 6;

    // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_src[1:0],instr_done,illegal_op}
    localparam logic [16:0] V_EXEC      = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [16:0] V_FETCH_STL = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] V_MEMRD     = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] V_MEMWB     = 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [16:0] V_BR1       = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] V_BR0       = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] V_JUMP      = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [16:0] V_SW        = 17'b0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [16:0] V_SW_STL    = 17'b0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] V_ILL       = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    wire [16:0] v32, v4;
    wire [31:0] cnt32;
    wire [3:0]  cnt4;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(v32[16]), .iord(v32[15]), .mem_read(v32[14]), .mem_write(v32[13]),
        .ir_write(v32[12]), .reg_dst(v32[11]), .mem_to_reg(v32[10]), .reg_write(v32[9]),
        .alu_src_a(v32[8]), .alu_src_b(v32[7:6]), .alu_op(v32[5:4]), .pc_src(v32[3:2]),
        .instr_done(v32[1]), .illegal_op(v32[0]), .instr_count(cnt32)
    );

    multicycle_control #(.MEM_WAIT_EN(1'b1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(v4[16]), .iord(v4[15]), .mem_read(v4[14]), .mem_write(v4[13]),
        .ir_write(v4[12]), .reg_dst(v4[11]), .mem_to_reg(v4[10]), .reg_write(v4[9]),
        .alu_src_a(v4[8]), .alu_src_b(v4[7:6]), .alu_op(v4[5:4]), .pc_src(v4[3:2]),
        .instr_done(v4[1]), .illegal_op(v4[0]), .instr_count(cnt4)
    );

    // ---------------- behavioural model ----------------
    int          m_step;
    int          m_cls;
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    wire  [16:0] m_exp;

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b000000: return C_R;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // Expected controls for step 'step' of an instruction of class 'cls'.
    function automatic logic [16:0] model_out(input int cls, input int step, input logic rdy,
                                              input logic z, input logic rn);
        logic pe, io, mr, mw, irw, rd, m2r, rw, sa, dn, il;
        logic [1:0] sb, ao, ps;
        {pe, io, mr, mw, irw, rd, m2r, rw, sa, dn, il} = 11'b0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        if (rn) begin
            if (step == 0) begin
                mr = 1'b1; sb = 2'b01; irw = rdy; pe = rdy;
            end else if (step == 1) begin
                sb = 2'b11;
            end else begin
                case (cls)
                    C_R: if (step == 2) begin sa = 1'b1; ao = 2'b10; end
                         else begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
                    C_ADDI: if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                            else begin rw = 1'b1; dn = 1'b1; end
                    C_LW: if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                          else if (step == 3) begin mr = 1'b1; io = 1'b1; end
                          else begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
                    C_SW: if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                          else begin mw = 1'b1; io = 1'b1; dn = rdy; end
                    C_BEQ: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; dn = 1'b1; end
                    C_J:   begin ps = 2'b10; pe = 1'b1; dn = 1'b1; end
                    default: il = 1'b1;
                endcase
            end
        end
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, dn, il};
    endfunction

    assign m_exp = model_out(m_cls, m_step, mem_ready, zero, rst_n);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_step <= 0; m_cls <= C_R; m_cnt <= 32'd0; m_cnt4 <= 4'd0;
        end else if (m_exp[1]) begin
            m_step <= 0; m_cnt <= m_cnt + 32'd1; m_cnt4 <= m_cnt4 + 4'd1;
        end else if (m_step == 0) begin
            if (mem_ready) m_step <= 1;
        end else if (m_step == 1) begin
            m_cls <= classify(opcode); m_step <= 2;
        end else if (m_cls == C_ILL) begin
            m_step <= m_step;
        end else if (m_step == 3 && (m_cls == C_LW || m_cls == C_SW) && !mem_ready) begin
            m_step <= m_step;
        end else begin
            m_step <= m_step + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("out32", {15'd0, v32}, {15'd0, m_exp});
        check("out4", {15'd0, v4}, {15'd0, m_exp});
        check("cnt32", cnt32, m_cnt);
        check("cnt4", {28'd0, cnt4}, {28'd0, m_cnt4});
    end

    // Runs one instruction from its FETCH cycle; mem_ready is low in cycles
    // [stall_at, stall_at+n_stall). Called at posedge+2.
    task automatic run_instr(input logic [5:0] op, input logic z, input int stall_at,
                             input int n_stall, input int exp_cyc, input int probe_cyc,
                             input logic [16:0] probe_val, input string nm);
        int  c;
        bit  done;
        c = 0; done = 1'b0;
        opcode = op; zero = z;
        while (!done && c < 40) begin
            c++;
            mem_ready = !(c >= stall_at && c < stall_at + n_stall);
            @(negedge clk); #1;
            if (c == probe_cyc) check({nm, "_probe"}, {15'd0, v32}, {15'd0, probe_val});
            if (v32[1]) done = 1'b1;
            @(posedge clk); #2;
        end
        mem_ready = 1'b1;
        check({nm, "_cycles"}, c, exp_cyc);
    endtask

    task automatic idle_cycle();
        @(negedge clk); #1;
        @(posedge clk); #2;
    endtask

    initial begin
        @(negedge clk); #1;
        check("reset_out", {15'd0, v32}, 32'd0);
        check("reset_cnt", cnt32, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        run_instr(OP_RTYPE, 1'b0, 0, 0, 4, 3, V_EXEC, "rtype");
        run_instr(OP_RTYPE, 1'b0, 0, 0, 4, 4, 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0, "rtype_wb");
        check("cnt_after_r", cnt32, 32'd2);
        run_instr(OP_RTYPE, 1'b0, 1, 2, 6, 1, V_FETCH_STL, "fetch_stall");
        run_instr(OP_LW, 1'b0, 4, 2, 7, 5, V_MEMRD, "lw_stall");
        run_instr(OP_LW, 1'b0, 0, 0, 5, 5, V_MEMWB, "lw");
        check("cnt_after_lw", cnt32, 32'd5);
        run_instr(OP_BEQ, 1'b1, 0, 0, 3, 3, V_BR1, "beq_taken");
        run_instr(OP_BEQ, 1'b0, 0, 0, 3, 3, V_BR0, "beq_not");
        run_instr(OP_J, 1'b0, 0, 0, 3, 3, V_JUMP, "jump");
        run_instr(OP_SW, 1'b0, 0, 0, 4, 4, V_SW, "sw");
        check("cnt_after_jsw", cnt32, 32'd9);
        run_instr(OP_SW, 1'b0, 4, 1, 5, 4, V_SW_STL, "sw_stall");
        check("cnt_after_swstall", cnt32, 32'd10);

        // Unsupported opcode traps and stays trapped.
        opcode = 6'b111111;
        idle_cycle();
        idle_cycle();
        opcode = OP_RTYPE;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            check("illegal_hold", {15'd0, v32}, {15'd0, V_ILL});
            check("illegal_cnt", cnt32, 32'd10);
            @(posedge clk); #2;
        end
        rst_n = 1'b0; #1;
        check("illegal_clr", {15'd0, v32}, 32'd0);
        check("illegal_clr_cnt", cnt32, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Reset during MEMADR discards the load.
        run_instr(OP_RTYPE, 1'b0, 0, 0, 4, 0, 17'd0, "pre_abort");
        opcode = OP_LW;
        idle_cycle();
        idle_cycle();
        #1 check("memadr_live", {15'd0, v32}, {15'd0, 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0});
        rst_n = 1'b0; #1;
        check("abort_out", {15'd0, v32}, 32'd0);
        check("abort_cnt", cnt32, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_instr(OP_RTYPE, 1'b0, 0, 0, 4, 0, 17'd0, "post_abort");
        check("post_abort_cnt", cnt32, 32'd1);

        // Narrow counter wraps 15 -> 0.
        for (int i = 0; i < 14; i++) run_instr(OP_ADDI, 1'b0, 0, 0, 4, 0, 17'd0, "addi");
        check("cnt4_15", {28'd0, cnt4}, 32'd15);
        run_instr(OP_ADDI, 1'b0, 0, 0, 4, 3, 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0, "addi_last");
        check("cnt4_wrap", {28'd0, cnt4}, 32'd0);
        check("cnt32_16", cnt32, 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
